// File: rtl/answer_pkg.sv
// Shared defaults and the sequencer state type for the answer path.
// Optional build macro used by this block: ANSWER_SEQ_ROUND_ROBIN_EN.
package answer_pkg;

    localparam int ANSWER_DEPTH  = 128;
    localparam int ANSWER_DATA_W = 8;
    localparam int ANSWER_SIZE_W = $clog2(ANSWER_DEPTH) + 1;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        DRAIN     = 2'd1,
        WAIT_DONE = 2'd2
    } answer_seq_state_t;

endpackage

// File: rtl/answer_req_arbiter.sv
// One-hot grant among byte producers. Fixed lowest-index priority by default;
// round-robin with a registered pointer when ANSWER_SEQ_ROUND_ROBIN_EN is defined.
module answer_req_arbiter #(
    parameter int NUM_REQ = 2
) (
`ifdef ANSWER_SEQ_ROUND_ROBIN_EN
    input  logic               clock,
    input  logic               reset,
`endif
    input  logic               i_enable,
    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;

`ifdef ANSWER_SEQ_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_ptr_next;

    // Search from the pointer upward, then wrap to the indices below it.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_enable && !w_found && i_req_valid[j] && (j >= int'(r_ptr))) begin
                o_grant[j] = 1'b1;
                w_found    = 1'b1;
                w_idx      = PTR_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_enable && !w_found && i_req_valid[j] && (j < int'(r_ptr))) begin
                o_grant[j] = 1'b1;
                w_found    = 1'b1;
                w_idx      = PTR_W'(j);
            end
        end
    end

    assign w_ptr_next = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_enable && !w_found && i_req_valid[j]) begin
                o_grant[j] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/answer_sequencer.sv
// Buffers producer bytes and streams them to the answer writer on flush or when full.
// Arbitration policy is selected by ANSWER_SEQ_ROUND_ROBIN_EN (fixed priority when undefined).
module answer_sequencer
    import answer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = ANSWER_DEPTH,
    parameter int DATA_W  = ANSWER_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic                      wr_valid,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      wr_last,
    input  logic                      wr_ready,
    output logic [$clog2(DEPTH):0]    answer_size,
    input  logic                      writer_done,
    output logic                      busy,
    output answer_seq_state_t         dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    answer_seq_state_t r_state;
    answer_seq_state_t w_next_state;

    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [SW-1:0]     r_count;
    logic [AW-1:0]     r_rd_ptr;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_arb_en;
    logic               w_accept;
    logic [DATA_W-1:0]  w_in_byte;
    logic [SW-1:0]      w_count_post;

    // Both sides use valid/ready: a byte moves on a cycle where valid and ready
    // are both high at the rising edge; the sender holds data stable until then.
    assign w_arb_en = !reset && (r_state == COLLECT) && (r_count < SW'(DEPTH));

    answer_req_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
`ifdef ANSWER_SEQ_ROUND_ROBIN_EN
        .clock       (clock),
        .reset       (reset),
`endif
        .i_enable    (w_arb_en),
        .i_req_valid (req_valid),
        .o_grant     (w_grant)
    );

    assign req_ready    = w_grant;
    assign w_accept     = |w_grant;
    assign w_count_post = r_count + {{AW{1'b0}}, w_accept};

    always_comb begin
        w_in_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_in_byte = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_buf[r_count[AW-1:0]] <= w_in_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if ((w_accept && (w_count_post == SW'(DEPTH))) ||
                    (flush && (w_count_post != '0))) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_ready && wr_last) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (writer_done) begin
                    w_next_state = COLLECT;
                end
            end
            default: w_next_state = COLLECT;
        endcase
    end

    // The read pointer stops on the last byte so a full buffer never wraps it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_count <= w_count_post;
                    end
                end
                DRAIN: begin
                    if (wr_ready && !wr_last) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (writer_done) begin
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_valid    = (r_state == DRAIN);
    assign wr_data     = (r_state == DRAIN) ? r_buf[r_rd_ptr] : '0;
    assign wr_last     = (r_state == DRAIN) && ({1'b0, r_rd_ptr} == (r_count - SW'(1)));
    assign answer_size = r_count;
    assign busy        = (r_state != COLLECT);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_answer_sequencer.sv
// Directed bench for answer_sequencer: reset, transfers, arbitration, full buffer,
// boundary handshakes and reset during a drain.
module tb_answer_sequencer;
  import answer_pkg::*;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [1:0]                 req_valid = '0;
  logic [15:0]                req_data = '0;
  logic [1:0]                 req_ready;
  logic                       flush = 1'b0;
  logic                       wr_valid;
  logic [7:0]                 wr_data;
  logic                       wr_last;
  logic                       wr_ready = 1'b0;
  logic [ANSWER_SIZE_W-1:0]   answer_size;
  logic                       writer_done = 1'b0;
  logic                       busy;
  answer_seq_state_t          dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  answer_sequencer #(
    .NUM_REQ (2),
    .DEPTH   (128),
    .DATA_W  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .answer_size (answer_size),
    .writer_done (writer_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  // Inputs change at the falling edge; outputs are checked 1 ns later.
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    @(negedge clock);
    @(negedge clock);
    #1;
    n_tests++;
    if ({req_ready, wr_valid, wr_data, wr_last, answer_size, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b wv=%b wd=%h wl=%b sz=%0d busy=%b, want all 0",
               req_ready, wr_valid, wr_data, wr_last, answer_size, busy);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_grant;
    logic [7:0] a = 8'hA0;
    logic [7:0] b = 8'hB0;
`ifdef ANSWER_SEQ_ROUND_ROBIN_EN
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
`else
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      req_valid = 2'b11;
      req_data = {b, a};
`ifdef ANSWER_SEQ_ROUND_ROBIN_EN
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b01;
`endif
      #1;
      n_tests++;
      if (req_ready !== exp_grant) begin
        n_fail++;
        $display("FAIL arb_grant[%0d]: got %b want %b", k, req_ready, exp_grant);
      end
      if (req_ready[0]) a = a + 8'd1;
      if (req_ready[1]) b = b + 8'd1;
    end
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b1;
    wr_ready = 1'b1;
    #1;
    n_tests++;
    if (answer_size !== 8'd4) begin
      n_fail++;
      $display("FAIL arb_size: got %0d want 4", answer_size);
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_b;
      @(negedge clock);
      flush = 1'b0;
      #1;
      exp_b = exp_q.pop_front();
      n_tests++;
      if ({wr_valid, wr_last, wr_data} !== {1'b1, (k == 3), exp_b}) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, wr_valid, wr_last, wr_data, (k == 3), exp_b);
      end
    end
    @(negedge clock);
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
    wr_ready = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_valid = 2'b01;
      req_data[7:0] = 8'h41 + 8'(i);
      #1;
      n_tests++;
      if (req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL basic_grant[%0d]: got %b want 01", i, req_ready);
      end
    end
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b1;
    wr_ready = 1'b1;
    #1;
    n_tests++;
    if ({answer_size, busy, wr_valid} !== {8'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_pre_flush: got sz=%0d busy=%b wv=%b want 3 0 0", answer_size, busy, wr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      flush = 1'b0;
      req_valid = 2'b01;
      #1;
      n_tests++;
      if ({wr_valid, wr_last, wr_data, answer_size, busy, req_ready} !==
          {1'b1, (i == 2), 8'h41 + 8'(i), 8'd3, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL basic_drain[%0d]: got v=%b l=%b d=%h sz=%0d busy=%b rdy=%b want v=1 l=%b d=%h sz=3 busy=1 rdy=00",
                 i, wr_valid, wr_last, wr_data, answer_size, busy, req_ready, (i == 2), 8'h41 + 8'(i));
      end
    end
    @(negedge clock);
    req_valid = 2'b00;
    #1;
    n_tests++;
    if ({wr_valid, wr_last, wr_data, busy, dbg_state} !== {1'b0, 1'b0, 8'h00, 1'b1, WAIT_DONE}) begin
      n_fail++;
      $display("FAIL basic_wait_done: got v=%b l=%b d=%h busy=%b st=%0d want 0 0 00 1 2",
               wr_valid, wr_last, wr_data, busy, dbg_state);
    end
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
    wr_ready = 1'b0;
    #1;
    n_tests++;
    if ({busy, answer_size, dbg_state} !== {1'b0, 8'd0, COLLECT}) begin
      n_fail++;
      $display("FAIL basic_done: got busy=%b sz=%0d st=%0d want 0 0 0", busy, answer_size, dbg_state);
    end
  endtask

  task automatic test_full();
    int bad_fill = 0;
    int bad_drain = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      req_valid = 2'b10;
      req_data[15:8] = 8'(i);
      #1;
      if (req_ready !== 2'b10) bad_fill++;
    end
    n_tests++;
    if (bad_fill != 0) begin
      n_fail++;
      $display("FAIL full_fill_grant: got %0d cycles without grant 10, want 0", bad_fill);
    end
    for (int j = 0; j < 128; j++) begin
      @(negedge clock);
      wr_ready = 1'b1;
      #1;
      if ({wr_valid, wr_last, wr_data, answer_size, req_ready} !==
          {1'b1, (j == 127), 8'(j), 8'd128, 2'b00}) begin
        bad_drain++;
        if (bad_drain < 4)
          $display("FAIL full_drain[%0d]: got v=%b l=%b d=%h sz=%0d rdy=%b want v=1 l=%b d=%h sz=128 rdy=00",
                   j, wr_valid, wr_last, wr_data, answer_size, req_ready, (j == 127), 8'(j));
      end
    end
    n_tests++;
    if (bad_drain != 0) begin
      n_fail++;
      $display("FAIL full_drain_total: got %0d bad beats, want 0", bad_drain);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if ({dbg_state, req_ready, wr_valid} !== {WAIT_DONE, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL full_wait_done: got st=%0d rdy=%b wv=%b want 2 00 0", dbg_state, req_ready, wr_valid);
    end
    req_valid = 2'b00;
    wr_ready = 1'b0;
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
  endtask

  task automatic test_flush_empty();
    @(negedge clock);
    flush = 1'b1;
    wr_ready = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    n_tests++;
    if ({wr_valid, busy, dbg_state} !== {1'b0, 1'b0, COLLECT}) begin
      n_fail++;
      $display("FAIL flush_empty: got wv=%b busy=%b st=%0d want 0 0 0", wr_valid, busy, dbg_state);
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_flush_same_cycle();
    @(negedge clock);
    req_valid = 2'b01;
    req_data[7:0] = 8'h5A;
    flush = 1'b1;
    wr_ready = 1'b1;
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b0;
    #1;
    n_tests++;
    if ({wr_valid, wr_last, wr_data, answer_size} !== {1'b1, 1'b1, 8'h5A, 8'd1}) begin
      n_fail++;
      $display("FAIL flush_same_cycle: got v=%b l=%b d=%h sz=%0d want 1 1 5a 1",
               wr_valid, wr_last, wr_data, answer_size);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if ({dbg_state, wr_valid} !== {WAIT_DONE, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_same_cycle_end: got st=%0d wv=%b want 2 0", dbg_state, wr_valid);
    end
    wr_ready = 1'b0;
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
  endtask

  task automatic test_wr_ready_toggle();
    logic [3:0] rdy_tab = 4'b1101;
    logic [7:0] d_tab [4] = '{8'h11, 8'h22, 8'h22, 8'h33};
    logic [3:0] l_tab = 4'b1000;
    logic [7:0] in_tab [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_valid = 2'b01;
      req_data[7:0] = in_tab[i];
    end
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      flush = 1'b0;
      wr_ready = rdy_tab[k];
      #1;
      n_tests++;
      if ({wr_valid, wr_last, wr_data} !== {1'b1, l_tab[k], d_tab[k]}) begin
        n_fail++;
        $display("FAIL ready_toggle[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 k, wr_valid, wr_last, wr_data, l_tab[k], d_tab[k]);
      end
    end
    @(negedge clock);
    wr_ready = 1'b0;
    #1;
    n_tests++;
    if ({dbg_state, wr_valid} !== {WAIT_DONE, 1'b0}) begin
      n_fail++;
      $display("FAIL ready_toggle_end: got st=%0d wv=%b want 2 0", dbg_state, wr_valid);
    end
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = 2'b01;
      req_data[7:0] = 8'h61 + 8'(i);
    end
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b1;
    wr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      flush = 1'b0;
      #1;
      n_tests++;
      if ({wr_valid, wr_last, wr_data} !== {1'b1, 1'b0, 8'h61 + 8'(k)}) begin
        n_fail++;
        $display("FAIL mid_drain[%0d]: got v=%b l=%b d=%h want 1 0 %h", k, wr_valid, wr_last, wr_data, 8'h61 + 8'(k));
      end
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({wr_valid, wr_last, answer_size, busy, dbg_state} !== {1'b0, 1'b0, 8'd0, 1'b0, COLLECT}) begin
      n_fail++;
      $display("FAIL mid_reset: got wv=%b wl=%b sz=%0d busy=%b st=%0d want 0 0 0 0 0",
               wr_valid, wr_last, answer_size, busy, dbg_state);
    end
    req_valid = 2'b01;
    req_data[7:0] = 8'h77;
    flush = 1'b1;
    @(negedge clock);
    req_valid = 2'b00;
    flush = 1'b0;
    #1;
    n_tests++;
    if ({wr_valid, wr_last, wr_data, answer_size} !== {1'b1, 1'b1, 8'h77, 8'd1}) begin
      n_fail++;
      $display("FAIL post_reset_transfer: got v=%b l=%b d=%h sz=%0d want 1 1 77 1",
               wr_valid, wr_last, wr_data, answer_size);
    end
    @(negedge clock);
    wr_ready = 1'b0;
    writer_done = 1'b1;
    @(negedge clock);
    writer_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_basic();
    test_full();
    test_flush_empty();
    test_flush_same_cycle();
    test_wr_ready_toggle();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
